// File: rtl/eth_pkg.sv
// eth_pkg: header lengths, protocol constants and parser states shared by the UDP/MoldUDP64 front end
package eth_pkg;
    localparam logic [5:0]  ETH_HDR_LEN    = 6'd14;
    localparam logic [5:0]  IP_HDR_LEN     = 6'd20;
    localparam logic [5:0]  UDP_HDR_LEN    = 6'd8;
    localparam logic [5:0]  MOLD_HDR_LEN   = 6'd20;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        ETH_HDR,
        IP_HDR,
        UDP_HDR,
        MOLD_HDR,
        MSG_LEN,
        MSG_DATA,
        DROP
    } parse_state_t;

    function automatic logic [5:0] hdrLen(parse_state_t s);
        return s == ETH_HDR  ? ETH_HDR_LEN :
               s == IP_HDR   ? IP_HDR_LEN :
               s == UDP_HDR  ? UDP_HDR_LEN :
               s == MOLD_HDR ? MOLD_HDR_LEN : 6'd0;
    endfunction
endpackage

// File: rtl/mold_msg_splitter.sv
// mold_msg_splitter: latches each big-endian ITCH length, counts the message bytes down and emits them with start/last marks
module mold_msg_splitter (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dataIn,
    input  logic        lenValid,
    input  logic        lenIdx,
    input  logic        dataValid,
    output logic        lenDone,
    output logic [15:0] lenWord,
    output logic        msgEnd,
    output logic [7:0]  itchData,
    output logic        itchValid,
    output logic        itchStart,
    output logic        itchLast,
    output logic [15:0] itchLen
);
    logic [7:0]  lenHi;
    logic [15:0] lenReg;
    logic [15:0] byteCnt;

    assign lenDone = lenValid && lenIdx;
    assign lenWord = {lenHi, dataIn};
    assign msgEnd  = dataValid && byteCnt == 16'd1;
    assign itchLen = lenReg;

    // length latch, remaining-byte countdown and one-cycle registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            lenHi     <= 8'd0;
            lenReg    <= 16'd0;
            byteCnt   <= 16'd0;
            itchData  <= 8'd0;
            itchValid <= 1'b0;
            itchStart <= 1'b0;
            itchLast  <= 1'b0;
        end else begin
            itchValid <= dataValid;
            itchStart <= dataValid && byteCnt == lenReg;
            itchLast  <= msgEnd;
            if (dataValid) itchData <= dataIn;
            if (lenValid && !lenIdx) lenHi <= dataIn;
            if (lenDone) begin
                lenReg  <= lenWord;
                byteCnt <= lenWord;
            end else if (dataValid) begin
                byteCnt <= byteCnt - 16'd1;
            end
        end
    end
endmodule

// File: rtl/udp_parser.sv
// udp_parser: validates Ethernet/IPv4/UDP/MoldUDP64 headers and splits the payload into ITCH messages; define UDP_PARSER_SEQ_CHECK_EN to add the seqGapOut sequence check
module udp_parser
    import eth_pkg::*;
#(
    parameter logic [15:0] UDP_DST_PORT = 16'd26477,
    parameter logic [15:0] MAX_MSG_LEN  = 16'd64
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic [7:0]  rxDataIn,
    input  logic        rxDataValidIn,
    input  logic        rxDataLastIn,
    output logic [7:0]  itchDataOut,
    output logic        itchDataValidOut,
    output logic        itchMsgStartOut,
    output logic        itchMsgLastOut,
    output logic [15:0] itchMsgLenOut,
`ifdef UDP_PARSER_SEQ_CHECK_EN
    output logic        seqGapOut,
    output logic        frameDropOut
`else
    output logic        frameDropOut
`endif
);
    parse_state_t state;
    parse_state_t stateNext;
    logic [5:0]   hdrCnt;
    logic [15:0]  msgRemaining;
    logic [7:0]   cntHi;
    logic [15:0]  msgCount;
    logic         resync;
    logic         hdrDone;
    logic         chkFail;
    logic         cleanEnd;
    logic         dropPulse;
    logic         lenDone;
    logic [15:0]  lenWord;
    logic         msgEnd;

    assign hdrDone  = hdrCnt == hdrLen(state) - 6'd1;
    assign msgCount = {cntHi, rxDataIn};

    mold_msg_splitter splitter (
        .clk      (clkIn),
        .rst      (rstIn),
        .dataIn   (rxDataIn),
        .lenValid (rxDataValidIn && state == MSG_LEN),
        .lenIdx   (hdrCnt[0]),
        .dataValid(rxDataValidIn && state == MSG_DATA),
        .lenDone  (lenDone),
        .lenWord  (lenWord),
        .msgEnd   (msgEnd),
        .itchData (itchDataOut),
        .itchValid(itchDataValidOut),
        .itchStart(itchMsgStartOut),
        .itchLast (itchMsgLastOut),
        .itchLen  (itchMsgLenOut)
    );

    // per-byte header checks, next state and drop decision; a clean end is the completion of the last message or a heartbeat
    always_comb begin
        stateNext = state;
        chkFail   = 1'b0;
        cleanEnd  = 1'b0;
        dropPulse = 1'b0;
        if (rxDataValidIn) begin
            case (state)
                IDLE: stateNext = (resync || rxDataLastIn) ? IDLE : ETH_HDR;
                ETH_HDR: begin
                    chkFail   = (hdrCnt == 6'd12 && rxDataIn != ETHERTYPE_IPV4[15:8]) ||
                                (hdrCnt == 6'd13 && rxDataIn != ETHERTYPE_IPV4[7:0]);
                    stateNext = hdrDone ? IP_HDR : ETH_HDR;
                end
                IP_HDR: begin
                    chkFail   = (hdrCnt == 6'd0 && rxDataIn != IPV4_VER_IHL) ||
                                (hdrCnt == 6'd9 && rxDataIn != IP_PROTO_UDP);
                    stateNext = hdrDone ? UDP_HDR : IP_HDR;
                end
                UDP_HDR: begin
                    chkFail   = (hdrCnt == 6'd2 && rxDataIn != UDP_DST_PORT[15:8]) ||
                                (hdrCnt == 6'd3 && rxDataIn != UDP_DST_PORT[7:0]);
                    stateNext = hdrDone ? MOLD_HDR : UDP_HDR;
                end
                MOLD_HDR: begin
                    cleanEnd  = hdrDone && (msgCount == 16'h0000 || msgCount == 16'hFFFF);
                    stateNext = cleanEnd ? DROP : hdrDone ? MSG_LEN : MOLD_HDR;
                end
                MSG_LEN: begin
                    chkFail   = lenDone && lenWord > MAX_MSG_LEN;
                    cleanEnd  = lenDone && lenWord == 16'd0 && msgRemaining == 16'd1;
                    stateNext = cleanEnd ? DROP : (lenDone && lenWord != 16'd0) ? MSG_DATA : MSG_LEN;
                end
                MSG_DATA: begin
                    cleanEnd  = msgEnd && msgRemaining == 16'd1;
                    stateNext = cleanEnd ? DROP : msgEnd ? MSG_LEN : MSG_DATA;
                end
                DROP: stateNext = DROP;
            endcase
            if (chkFail) stateNext = DROP;
            dropPulse = chkFail ||
                        (rxDataLastIn && state != IDLE && state != DROP && !cleanEnd) ||
                        (rxDataLastIn && state == IDLE && !resync);
            if (rxDataLastIn) stateNext = IDLE;
        end
    end

    // state, header counter, message budget; reset mid-frame arms resync so the frame tail is skipped
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state        <= IDLE;
            hdrCnt       <= 6'd0;
            msgRemaining <= 16'd0;
            cntHi        <= 8'd0;
            frameDropOut <= 1'b0;
            resync       <= rxDataValidIn ? !rxDataLastIn : (state != IDLE || resync);
        end else begin
            frameDropOut <= dropPulse;
            if (rxDataValidIn) begin
                state  <= stateNext;
                hdrCnt <= stateNext != state ? {5'd0, state == IDLE} :
                          lenDone ? 6'd0 :
                          state inside {ETH_HDR, IP_HDR, UDP_HDR, MOLD_HDR, MSG_LEN} ? hdrCnt + 6'd1 : hdrCnt;
                if (state == MOLD_HDR && hdrCnt == 6'd18) cntHi <= rxDataIn;
                msgRemaining <= (state == MOLD_HDR && hdrDone) ? msgCount :
                                (msgEnd || (lenDone && lenWord == 16'd0)) ? msgRemaining - 16'd1 : msgRemaining;
                if (state == IDLE && rxDataLastIn) resync <= 1'b0;
            end
        end
    end

`ifdef UDP_PARSER_SEQ_CHECK_EN
    logic [63:0] seqShift;
    logic [63:0] expectedSeq;
    logic [63:0] seqNow;
    logic        seqHave;

    assign seqNow = {seqShift[55:0], rxDataIn};

    // capture the MoldUDP64 sequence, flag a gap against the expected value and advance it by msgCount
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            seqShift    <= 64'd0;
            expectedSeq <= 64'd0;
            seqHave     <= 1'b0;
            seqGapOut   <= 1'b0;
        end else begin
            seqGapOut <= rxDataValidIn && state == MOLD_HDR && hdrCnt == 6'd17 && seqHave && seqNow != expectedSeq;
            if (rxDataValidIn && state == MOLD_HDR) begin
                if (hdrCnt >= 6'd10 && hdrCnt <= 6'd17) seqShift <= seqNow;
                if (hdrCnt == 6'd17 && !seqHave) begin
                    expectedSeq <= seqNow;
                    seqHave     <= 1'b1;
                end
                if (hdrDone) expectedSeq <= seqShift + {48'd0, msgCount};
            end
        end
    end
`endif
endmodule

// File: tb/tb_udp_parser.sv
// tb_udp_parser: directed frames through udp_parser with hand-built expected ITCH byte streams
module tb_udp_parser;
    typedef struct {
        logic [7:0]  data;
        logic        start;
        logic        last;
        logic [15:0] len;
        int          idx;
    } expByte_t;

    typedef struct {
        logic [7:0]  data;
        logic        start;
        logic        last;
        logic [15:0] len;
        int          cyc;
    } obsByte_t;

    logic        clk = 1'b0;
    logic        rstIn = 1'b1;
    logic [7:0]  rxDataIn = 8'd0;
    logic        rxDataValidIn = 1'b0;
    logic        rxDataLastIn = 1'b0;
    logic [7:0]  itchDataOut;
    logic        itchDataValidOut;
    logic        itchMsgStartOut;
    logic        itchMsgLastOut;
    logic [15:0] itchMsgLenOut;
    logic        frameDropOut;
`ifdef UDP_PARSER_SEQ_CHECK_EN
    logic        seqGapOut;
`endif

    logic [7:0]  frame[$];
    expByte_t    expQ[$];
    obsByte_t    gotQ[$];
    int          driveCyc[256];
    int          cyc = 0;
    int          drops = 0;
    int          gaps = 0;
    int          rstArmed = 0;
    logic [27:0] postRst = '1;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] seq = 64'd100;

    udp_parser dut (
        .clkIn           (clk),
        .rstIn           (rstIn),
        .rxDataIn        (rxDataIn),
        .rxDataValidIn   (rxDataValidIn),
        .rxDataLastIn    (rxDataLastIn),
        .itchDataOut     (itchDataOut),
        .itchDataValidOut(itchDataValidOut),
        .itchMsgStartOut (itchMsgStartOut),
        .itchMsgLastOut  (itchMsgLastOut),
        .itchMsgLenOut   (itchMsgLenOut),
`ifdef UDP_PARSER_SEQ_CHECK_EN
        .seqGapOut       (seqGapOut),
`endif
        .frameDropOut    (frameDropOut)
    );

    always #2 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (itchDataValidOut)
            gotQ.push_back('{itchDataOut, itchMsgStartOut, itchMsgLastOut, itchMsgLenOut, cyc});
        if (frameDropOut) drops++;
`ifdef UDP_PARSER_SEQ_CHECK_EN
        if (seqGapOut) gaps++;
`endif
        if (rstArmed != 0) begin
            postRst  = {itchDataOut, itchDataValidOut, itchMsgStartOut, itchMsgLastOut, itchMsgLenOut, frameDropOut};
            rstArmed = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pushN(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) frame.push_back(v[8*i +: 8]);
    endtask

    task automatic newFrame(input logic [15:0] etherType, input logic [15:0] port,
                            input logic [63:0] sq, input logic [15:0] count);
        frame.delete();
        expQ.delete();
        pushN(64'h0000_1122_3344_5566, 6);
        pushN(64'h0000_AABB_CCDD_EEFF, 6);
        pushN({48'd0, etherType}, 2);
        pushN(64'h4500_0054_1234_4000, 8);
        pushN(64'h0000_0000_4011_0000, 4);
        pushN(64'h0000_0000_0A00_0001, 4);
        pushN(64'h0000_0000_E000_0001, 4);
        pushN(64'd5000, 2);
        pushN({48'd0, port}, 2);
        pushN(64'h0000_0000_0040_0000, 4);
        pushN(64'h4E41_5344_4151_3031, 8);
        pushN(64'h2020, 2);
        pushN(sq, 8);
        pushN({48'd0, count}, 2);
    endtask

    task automatic addMsg(input int len, input logic [7:0] base);
        pushN(64'(len), 2);
        for (int k = 0; k < len; k++) begin
            frame.push_back(base + 8'(k));
            expQ.push_back('{base + 8'(k), k == 0, k == len - 1, 16'(len), frame.size() - 1});
        end
    endtask

    task automatic dropExpFrom(input int n);
        while (expQ.size() > 0 && expQ[$].idx >= n) void'(expQ.pop_back());
    endtask

    task automatic sendFrame(input int bubblePct, input int rstAt);
        for (int i = 0; i < frame.size(); i++) begin
            for (int b = 0; b < 3 && $urandom_range(99) < bubblePct; b++) begin
                @(negedge clk);
                rxDataValidIn = 1'b0;
                rxDataLastIn  = 1'($urandom);
                rxDataIn      = 8'($urandom);
                rstIn         = 1'b0;
            end
            @(negedge clk);
            rxDataIn      = frame[i];
            rxDataValidIn = 1'b1;
            rxDataLastIn  = i == frame.size() - 1;
            rstIn         = i == rstAt;
            if (i == rstAt) rstArmed = 1;
            driveCyc[i] = cyc;
        end
        @(negedge clk);
        rxDataValidIn = 1'b0;
        rxDataLastIn  = 1'b0;
        rstIn         = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic compareOut(input string tag, input int expDrops);
        check({tag, " count"}, 64'(gotQ.size()), 64'(expQ.size()));
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
            check($sformatf("%s byte%0d", tag, i),
                  {38'd0, gotQ[i].data, gotQ[i].start, gotQ[i].last, gotQ[i].len},
                  {38'd0, expQ[i].data, expQ[i].start, expQ[i].last, expQ[i].len});
            check($sformatf("%s latency%0d", tag, i), 64'(gotQ[i].cyc - driveCyc[expQ[i].idx]), 64'd1);
        end
        check({tag, " drops"}, 64'(drops), 64'(expDrops));
        gotQ.delete();
        drops = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset outputs",
              {36'd0, itchDataOut, itchDataValidOut, itchMsgStartOut, itchMsgLastOut, itchMsgLenOut, frameDropOut},
              64'd0);
        rstIn = 1'b0;
        repeat (2) @(negedge clk);

        newFrame(16'h0800, 16'd26477, seq, 16'd2);
        addMsg(3, 8'hA1);
        addMsg(1, 8'hB1);
        sendFrame(0, -1);
        compareOut("basic", 0);
        seq += 2;

        newFrame(16'h0800, 16'd26477, seq, 16'd2);
        addMsg(3, 8'hA1);
        addMsg(1, 8'hB1);
        sendFrame(30, -1);
        compareOut("bubbles", 0);
        seq += 2;

        newFrame(16'h86DD, 16'd26477, seq, 16'd1);
        addMsg(2, 8'h11);
        expQ.delete();
        sendFrame(0, -1);
        compareOut("ethertype", 1);

        newFrame(16'h0800, 16'd1234, seq, 16'd1);
        addMsg(2, 8'h21);
        expQ.delete();
        sendFrame(20, -1);
        compareOut("udp port", 1);

        newFrame(16'h0800, 16'd26477, seq, 16'd0);
        sendFrame(0, -1);
        compareOut("heartbeat", 0);

        newFrame(16'h0800, 16'd26477, seq, 16'd1);
        addMsg(1, 8'hC5);
        sendFrame(0, -1);
        compareOut("after heartbeat", 0);
        seq += 1;

        newFrame(16'h0800, 16'd26477, seq, 16'd2);
        addMsg(0, 8'h00);
        addMsg(1, 8'hC1);
        pushN(64'hFFFF, 2);
        sendFrame(30, -1);
        compareOut("zero length", 0);
        seq += 2;

        newFrame(16'h0800, 16'd26477, seq, 16'd1);
        addMsg(64, 8'h00);
        sendFrame(0, -1);
        compareOut("len 64", 0);
        seq += 1;

        newFrame(16'h0800, 16'd26477, seq, 16'd1);
        addMsg(65, 8'h40);
        expQ.delete();
        sendFrame(0, -1);
        compareOut("len 65", 1);
        seq += 1;

        newFrame(16'h0800, 16'd26477, seq, 16'd1);
        addMsg(5, 8'hD1);
        while (frame.size() > 66) void'(frame.pop_back());
        dropExpFrom(66);
        sendFrame(0, -1);
        compareOut("truncated", 1);
        seq += 1;

        newFrame(16'h0800, 16'd26477, seq, 16'd1);
        addMsg(2, 8'hF1);
        sendFrame(0, -1);
        compareOut("after truncation", 0);
        seq += 1;

        newFrame(16'h0800, 16'd26477, seq, 16'd1);
        addMsg(5, 8'hE1);
        dropExpFrom(66);
        sendFrame(0, 66);
        compareOut("reset mid message", 0);
        check("post reset outputs", {36'd0, postRst}, 64'd0);

        seq = 64'd100;
        newFrame(16'h0800, 16'd26477, seq, 16'd2);
        addMsg(1, 8'h71);
        addMsg(2, 8'h81);
        sendFrame(0, -1);
        compareOut("after reset", 0);

`ifdef UDP_PARSER_SEQ_CHECK_EN
        newFrame(16'h0800, 16'd26477, 64'd103, 16'd1);
        addMsg(1, 8'h91);
        sendFrame(0, -1);
        compareOut("seq gap frame", 0);
        check("seq gap pulses", 64'(gaps), 64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/udp_parser.md
Name: udp_parser

Overview:
- Byte-stream parser in the clk250 domain, downstream of the rxClkLcl→250 MHz CDC.
- Consumes a received Ethernet frame (no preamble, no FCS) and validates the Ethernet/IPv4/UDP headers.
- Strips the MoldUDP64 header and splits the payload into length-prefixed ITCH messages.
- Emits each ITCH message as a byte stream with start/last markers and its length, for the order-book stage.

Parameters:
- UDP_DST_PORT, 16'd26477: UDP destination port accepted; other ports are dropped.
- MAX_MSG_LEN, 16'd64: messages with a longer length field abort the frame.

Ports:
- clkIn  in  1  250 MHz clock.
- rstIn  in  1  Reset. Synchronous to clkIn, active-high.
- rxDataIn  in  8  Frame byte; first byte is the destination MAC MSB.
- rxDataValidIn  in  1  rxDataIn valid. May deassert at any cycle mid-frame (bubbles).
- rxDataLastIn  in  1  Final frame byte; qualified by rxDataValidIn.
- itchDataOut  out  8  ITCH message byte.
- itchDataValidOut  out  1  itchDataOut valid.
- itchMsgStartOut  out  1  First byte of a message.
- itchMsgLastOut  out  1  Last byte of a message.
- itchMsgLenOut  out  16  Length of the current message; stable from start through last.
- frameDropOut  out  1  One-cycle pulse when a frame is rejected or truncated.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset mid-frame discards the frame; the parser resyncs on the next valid byte after the next rxDataLastIn.
- Only cycles with rxDataValidIn high advance state and counters. Bubbles hold all state.
- Latency: output byte registered 1 cycle after the accepted input byte. No backpressure.
- Header byte counter hdrCnt[5:0] resets on every state change.
- State transitions:
  - IDLE: first valid byte moves to ETH_HDR with hdrCnt=1.
  - ETH_HDR: 14 bytes. EtherType (bytes 12–13) must equal 0x0800.
  - IP_HDR: 20 bytes. Byte 0 must equal 0x45. Protocol (byte 9) must equal 17. Options are unsupported (IHL≠5 → drop).
  - UDP_HDR: 8 bytes. Dest port (bytes 2–3) must equal UDP_DST_PORT.
  - MOLD_HDR: 20 bytes: session[10], sequence[8], msgCount[2]. msgCount 0x0000 (heartbeat) or 0xFFFF (end of session) → DROP without pulsing frameDropOut.
  - MSG_LEN: 2 bytes, big-endian, latched into lenReg. Length 0 → count the message as consumed, stay in MSG_LEN. Length >MAX_MSG_LEN → DROP with a frameDropOut pulse.
  - MSG_DATA: emit lenReg bytes. Byte 1 gets itchMsgStartOut; byte lenReg gets itchMsgLastOut; a length-1 message gets both on one byte. After the last byte, decrement msgRemaining; nonzero → MSG_LEN, zero → DROP (trailing padding ignored, no pulse).
  - DROP: discard until rxDataLastIn.
- Check failures: checks run per byte. Any mismatch → DROP plus a one-cycle frameDropOut pulse.
- rxDataLastIn handling:
  - Accepted in any non-IDLE state → IDLE on the next cycle.
  - If it arrives before msgRemaining reaches 0 (including during a header or mid-message), pulse frameDropOut.
  - A partially emitted message is terminated with no itchMsgLastOut; downstream discards the message on frameDropOut.
  - rxDataLastIn on the last byte of the last message is a clean end: itchMsgLastOut fires, no pulse.
- Arithmetic: msgRemaining and byte counters are 16-bit unsigned; neither wraps, because transitions occur at 0.

Optional Feature:
- Macro: UDP_PARSER_SEQ_CHECK_EN.
- When defined:
  - A 64-bit expectedSeq register is added. It is set from the first accepted MoldUDP64 sequence after reset.
  - Port seqGapOut (out, 1) pulses one cycle after the last sequence byte when the received sequence ≠ expectedSeq.
  - expectedSeq is reloaded as received sequence + msgCount at the end of MOLD_HDR.
- When undefined: no port, no register; behaviour is otherwise identical.

Decomposition:
- Package eth_pkg holds:
  - Constants: ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8, MOLD_HDR_LEN=20, ETHERTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'd17, IPV4_VER_IHL=8'h45.
  - typedef enum parse_state_t {IDLE, ETH_HDR, IP_HDR, UDP_HDR, MOLD_HDR, MSG_LEN, MSG_DATA, DROP}.
- Sub-module mold_msg_splitter covers the MSG_LEN/MSG_DATA logic (length latch, byte countdown, start/last generation). The header FSM stays in udp_parser.

Test Plan:
- Valid frame, port 26477, msgCount=2, lengths 3 and 1 → 4 output bytes. Start on bytes 1 and 4; last on bytes 3 and 4; itchMsgLenOut 3 then 1; no frameDropOut.
- Same frame with random rxDataValidIn bubbles (~30%) → identical output byte sequence, each byte 1 cycle after its input.
- EtherType 0x86DD, and separately UDP dst port 1234 → no itch output; frameDropOut pulses once.
- msgCount=0 heartbeat → no output, no frameDropOut. Next valid frame parses normally.
- rxDataLastIn on byte 2 of a 5-byte message → bytes 1–2 emitted, no itchMsgLastOut, frameDropOut pulse. A following good frame parses correctly.
- rstIn asserted mid-MSG_DATA for 1 cycle → all outputs 0 next cycle; the rest of that frame is ignored; the next frame parses. With UDP_PARSER_SEQ_CHECK_EN: seq 100 with count 2, then seq 103 → seqGapOut pulses once.
